// File: rtl/program_loader.sv
// Byte-stream program loader: assembles big-endian 32-bit words from a valid/ready stream,
// writes them to instruction memory, then launches the processor and waits for it to finish.
module program_loader #(
  parameter int unsigned INSTR_BIT = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 in_valid,
  input  logic [7:0]           in_data,
  output logic                 in_ready,
  output logic                 imem_we,
  output logic [INSTR_BIT-1:0] imem_addr,
  output logic [31:0]          imem_wdata,
  output logic                 St,
  input  logic                 proc_done,
  output logic                 busy,
  output logic                 err,
  output logic [15:0]          words_loaded
);

  localparam int unsigned MAX_WORDS = (32'd1 << INSTR_BIT) >> 2;
  localparam int unsigned CNT_W     = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR1,
    S_LOAD,
    S_DRAIN,
    S_START,
    S_RUN
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     n_q, n_d;
  logic [1:0]           byte_cnt_q, byte_cnt_d;
  logic [CNT_W-1:0]     word_cnt_q, word_cnt_d;
  logic [23:0]          asm_q, asm_d;
  logic                 in_ready_q, in_ready_d;
  logic                 imem_we_q, imem_we_d;
  logic [INSTR_BIT-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]          imem_wdata_q, imem_wdata_d;
  logic                 st_q, st_d;
  logic                 busy_q, busy_d;
  logic                 err_q, err_d;
  logic [CNT_W-1:0]     words_loaded_q, words_loaded_d;

  logic                 accept;
  logic [CNT_W-1:0]     n_full;
  logic [CNT_W-1:0]     word_next;
  logic                 last_word;

  assign accept    = in_valid & in_ready_q;
  assign n_full    = {n_q[15:8], in_data};
  assign word_next = word_cnt_q + 16'd1;
  // 17-bit compare so the increment cannot alias when N is at its 16-bit maximum.
  assign last_word = ((17'(word_cnt_q) + 17'd1) == 17'(n_q));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q        <= S_IDLE;
      n_q            <= '0;
      byte_cnt_q     <= '0;
      word_cnt_q     <= '0;
      asm_q          <= '0;
      in_ready_q     <= 1'b0;
      imem_we_q      <= 1'b0;
      imem_addr_q    <= '0;
      imem_wdata_q   <= '0;
      st_q           <= 1'b0;
      busy_q         <= 1'b0;
      err_q          <= 1'b0;
      words_loaded_q <= '0;
    end else begin
      state_q        <= state_d;
      n_q            <= n_d;
      byte_cnt_q     <= byte_cnt_d;
      word_cnt_q     <= word_cnt_d;
      asm_q          <= asm_d;
      in_ready_q     <= in_ready_d;
      imem_we_q      <= imem_we_d;
      imem_addr_q    <= imem_addr_d;
      imem_wdata_q   <= imem_wdata_d;
      st_q           <= st_d;
      busy_q         <= busy_d;
      err_q          <= err_d;
      words_loaded_q <= words_loaded_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    n_d            = n_q;
    byte_cnt_d     = byte_cnt_q;
    word_cnt_d     = word_cnt_q;
    asm_d          = asm_q;
    imem_we_d      = 1'b0;
    imem_addr_d    = imem_addr_q;
    imem_wdata_d   = imem_wdata_q;
    err_d          = err_q;
    words_loaded_d = words_loaded_q;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          n_d[15:8]      = in_data;
          err_d          = 1'b0;
          words_loaded_d = '0;
          state_d        = S_HDR1;
        end
      end
      S_HDR1: begin
        if (accept) begin
          n_d[7:0]   = in_data;
          byte_cnt_d = '0;
          word_cnt_d = '0;
          if (n_full == '0) begin
            state_d = S_IDLE;
          end else if (32'(n_full) > MAX_WORDS) begin
            err_d   = 1'b1;
            state_d = S_DRAIN;
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (accept) begin
          asm_d      = {asm_q[15:0], in_data};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            imem_we_d      = 1'b1;
            imem_addr_d    = INSTR_BIT'({word_cnt_q, 2'b00});
            imem_wdata_d   = {asm_q, in_data};
            words_loaded_d = word_next;
            word_cnt_d     = word_next;
            if (last_word) begin
              state_d = S_START;
            end
          end
        end
      end
      S_DRAIN: begin
        // {word_cnt, byte_cnt} acts as one byte counter running to 4*N.
        if (accept) begin
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            word_cnt_d = word_next;
            if (last_word) begin
              state_d = S_IDLE;
            end
          end
        end
      end
      S_START: begin
        state_d = S_RUN;
      end
      S_RUN: begin
        if (proc_done) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    in_ready_d = (state_d == S_IDLE) || (state_d == S_HDR1) ||
                 (state_d == S_LOAD) || (state_d == S_DRAIN);
    busy_d     = (state_d != S_IDLE);
    st_d       = (state_d == S_START);
  end

  assign in_ready     = in_ready_q;
  assign imem_we      = imem_we_q;
  assign imem_addr    = imem_addr_q;
  assign imem_wdata   = imem_wdata_q;
  assign St           = st_q;
  assign busy         = busy_q;
  assign err          = err_q;
  assign words_loaded = words_loaded_q;

endmodule

// File: tb/tb_program_loader.sv
// Randomized directed bench for program_loader; expected writes come from a frame-level model.
module tb_program_loader;

  localparam int unsigned INSTR_BIT = 8;

  logic                 CLK = 1'b0;
  logic                 RST;
  logic                 in_valid;
  logic [7:0]           in_data;
  logic                 in_ready;
  logic                 imem_we;
  logic [INSTR_BIT-1:0] imem_addr;
  logic [31:0]          imem_wdata;
  logic                 St;
  logic                 proc_done;
  logic                 busy;
  logic                 err;
  logic [15:0]          words_loaded;

  program_loader #(.INSTR_BIT(INSTR_BIT)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .imem_we     (imem_we),
    .imem_addr   (imem_addr),
    .imem_wdata  (imem_wdata),
    .St          (St),
    .proc_done   (proc_done),
    .busy        (busy),
    .err         (err),
    .words_loaded(words_loaded)
  );

  always #5 CLK = ~CLK;

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          st_cnt = 0;
  int          st_cyc = -1;
  int          last_we_cyc = -1;
  logic        st_busy = 1'b0;
  logic [39:0] wr_q[$];
  logic [31:0] words_q[$];

  // Observer: logs every write strobe and start pulse, sampled mid-cycle.
  always @(negedge CLK) begin
    cyc = cyc + 1;
    if (imem_we === 1'b1) begin
      wr_q.push_back({imem_addr, imem_wdata});
      last_we_cyc = cyc;
    end
    if (St === 1'b1) begin
      st_cnt  = st_cnt + 1;
      st_cyc  = cyc;
      st_busy = busy;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int gap_of(input int mode);
    return (mode < 0) ? int'($urandom_range(0, 2)) : mode;
  endfunction

  // Called at a negedge; returns at the negedge after the byte was accepted plus gap cycles.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 50) check("ready_timeout", 64'd0, 64'd1);
    @(negedge CLK);
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    repeat (gap) @(negedge CLK);
  endtask

  // Sends the frame held in words_q and checks writes, start pulse and completion.
  task automatic load_frame(input int gap_mode);
    int          n  = words_q.size();
    int          wb = wr_q.size();
    int          sb = st_cnt;
    logic [31:0] w;
    logic [39:0] e;
    logic [15:0] nn = 16'(n);
    send_byte(nn[15:8], gap_of(gap_mode));
    send_byte(nn[7:0], gap_of(gap_mode));
    for (int i = 0; i < n; i++) begin
      w = words_q[i];
      for (int j = 3; j >= 0; j--) send_byte(w[8*j +: 8], gap_of(gap_mode));
    end
    for (int k = 0; k < 20 && st_cnt == sb; k++) @(negedge CLK);
    repeat (2) @(negedge CLK);
    check("st_count", 64'(st_cnt - sb), 64'd1);
    check("st_with_last_we", 64'(st_cyc), 64'(last_we_cyc));
    check("busy_at_st", 64'(st_busy), 64'd1);
    check("wr_count", 64'(wr_q.size() - wb), 64'(n));
    for (int i = 0; i < n && (wb + i) < wr_q.size(); i++) begin
      e = {8'(4 * i), words_q[i]};
      check("wr_addr_data", 64'(wr_q[wb + i]), 64'(e));
    end
    check("run_in_ready", 64'(in_ready), 64'd0);
    check("run_busy", 64'(busy), 64'd1);
    check("words_loaded", 64'(words_loaded), 64'(n));
    proc_done = 1'b1;
    @(negedge CLK);
    proc_done = 1'b0;
    check("done_busy", 64'(busy), 64'd0);
    check("done_in_ready", 64'(in_ready), 64'd1);
  endtask

  initial begin
    int wb;
    int sb;
    int nw;
    RST       = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    proc_done = 1'b0;
    repeat (3) @(negedge CLK);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_imem_we", 64'(imem_we), 64'd0);
    check("rst_st", 64'(St), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_addr", 64'(imem_addr), 64'd0);
    check("rst_wdata", 64'(imem_wdata), 64'd0);
    check("rst_words", 64'(words_loaded), 64'd0);
    RST = 1'b1;
    #1;
    check("rel_in_ready_0", 64'(in_ready), 64'd0);
    @(negedge CLK);
    check("rel_in_ready_1", 64'(in_ready), 64'd1);
    check("rel_busy", 64'(busy), 64'd0);

    // Reference frame, back-to-back then with 3-cycle gaps.
    words_q = '{32'h11223344, 32'hAABBCCDD};
    load_frame(0);
    load_frame(3);

    // Empty program.
    wb = wr_q.size();
    sb = st_cnt;
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    repeat (3) @(negedge CLK);
    check("n0_busy", 64'(busy), 64'd0);
    check("n0_err", 64'(err), 64'd0);
    check("n0_writes", 64'(wr_q.size() - wb), 64'd0);
    check("n0_st", 64'(st_cnt - sb), 64'd0);
    check("n0_in_ready", 64'(in_ready), 64'd1);

    // Random programs, first one at the maximum size.
    for (int r = 0; r < 4; r++) begin
      nw = (r == 0) ? 64 : int'($urandom_range(1, 10));
      words_q.delete();
      for (int i = 0; i < nw; i++) words_q.push_back($urandom);
      load_frame(-1);
    end

    // Oversized header is drained without writes.
    wb = wr_q.size();
    sb = st_cnt;
    send_byte(8'h00, 0);
    send_byte(8'h41, 0);
    check("ovf_err_set", 64'(err), 64'd1);
    check("ovf_busy", 64'(busy), 64'd1);
    for (int i = 0; i < 259; i++) send_byte(8'($urandom), gap_of(-1));
    check("ovf_busy_259", 64'(busy), 64'd1);
    send_byte(8'($urandom), 0);
    repeat (2) @(negedge CLK);
    check("ovf_idle", 64'(busy), 64'd0);
    check("ovf_err_sticky", 64'(err), 64'd1);
    check("ovf_writes", 64'(wr_q.size() - wb), 64'd0);
    check("ovf_st", 64'(st_cnt - sb), 64'd0);
    send_byte(8'h00, 0);
    check("ovf_err_clear", 64'(err), 64'd0);
    send_byte(8'h00, 0);
    check("ovf_n0_idle", 64'(busy), 64'd0);

    // Reset in the middle of a load.
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    for (int i = 0; i < 6; i++) send_byte(8'($urandom_range(1, 255)), 0);
    RST = 1'b0;
    #1;
    check("mid_rst_in_ready", 64'(in_ready), 64'd0);
    check("mid_rst_we", 64'(imem_we), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_wdata", 64'(imem_wdata), 64'd0);
    check("mid_rst_words", 64'(words_loaded), 64'd0);
    sb = st_cnt;
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    check("mid_rst_no_st", 64'(st_cnt - sb), 64'd0);
    words_q = '{32'($urandom)};
    load_frame(0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
